sync_flywheel: RTL and testbench

SYNC_FLYWHEEL -- requirements
Module: sync_flywheel

---
 rtl/sync_flywheel.sv | 164 ++++++++++++++++
 tb/tb_sync_flywheel.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_flywheel.sv
// Flywheel sync regenerator: locks to the period of an external sync signal and
// bridges missing edges with synthetic pulses while locked.
//
// state   | meaning
// IDLE    | no signal, or waiting for the first edge
// ACQUIRE | measuring periods until LOCK_COUNT consistent ones are seen
// LOCKED  | reference frozen, pulses regenerated, missing edges synthesized
module sync_flywheel #(
    parameter int WIDTH      = 32,
    parameter int PERIOD_TOL = 2,
    parameter int LOCK_COUNT = 4,
    parameter int MISS_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             signal,
    input  logic             signal_exitence,
    output logic             sync_pulse,
    output logic             synth_flag,
    output logic             locked,
    output logic [WIDTH-1:0] period
);

    localparam int MCW    = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam int MSW    = (MISS_LIMIT > 0) ? $clog2(MISS_LIMIT + 1) : 1;
    localparam int LOCK_M = (LOCK_COUNT > 1) ? LOCK_COUNT - 2 : 0;

    localparam logic [WIDTH:0]   TOL_X = (WIDTH + 1)'(PERIOD_TOL);
    localparam logic [WIDTH-1:0] TOL_W = WIDTH'(PERIOD_TOL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             sync_1, sync_2;
    logic             edge_det;
    logic [WIDTH-1:0] phase_cnt, phase_next;
    logic [WIDTH-1:0] ref_period, ref_next;
    logic             ref_valid, ref_valid_next;
    logic [MCW-1:0]   match_cnt, match_next;
    logic [MSW-1:0]   miss_cnt, miss_next;
    logic             pulse_next, synth_next;

    logic [WIDTH:0]   meas_x, ref_x, lo_x, hi_x;
    logic [WIDTH-1:0] meas_sat;
    logic             in_tol;

    assign edge_det = sync_1 & ~sync_2;

    // Extra bit keeps the tolerance window from wrapping at either end.
    assign meas_x   = {1'b0, phase_cnt} + (WIDTH + 1)'(1);
    assign meas_sat = meas_x[WIDTH] ? '1 : meas_x[WIDTH-1:0];
    assign ref_x    = {1'b0, ref_period};
    assign lo_x     = (ref_x >= TOL_X) ? ref_x - TOL_X : '0;
    assign hi_x     = ref_x + TOL_X;
    assign in_tol   = (meas_x >= lo_x) && (meas_x <= hi_x);

    always_comb begin
        state_next     = state;
        ref_next       = ref_period;
        ref_valid_next = ref_valid;
        match_next     = match_cnt;
        miss_next      = miss_cnt;
        pulse_next     = 1'b0;
        synth_next     = 1'b0;
        if (edge_det)
            phase_next = '0;
        else if (&phase_cnt)
            phase_next = phase_cnt;
        else
            phase_next = phase_cnt + WIDTH'(1);

        if (!signal_exitence) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (edge_det) begin
                        state_next     = ACQUIRE;
                        ref_valid_next = 1'b0;
                        match_next     = '0;
                    end
                end
                ACQUIRE: begin
                    if (edge_det) begin
                        if (!ref_valid) begin
                            ref_next       = meas_sat;
                            ref_valid_next = 1'b1;
                            match_next     = '0;
                        end else if (in_tol) begin
                            if (match_cnt == MCW'(LOCK_M)) begin
                                state_next = LOCKED;
                                miss_next  = '0;
                            end else begin
                                match_next = match_cnt + MCW'(1);
                            end
                        end else begin
                            ref_next   = meas_sat;
                            match_next = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (edge_det) begin
                        if (meas_x < lo_x) begin
                            state_next     = ACQUIRE;
                            ref_next       = meas_sat;
                            ref_valid_next = 1'b1;
                            match_next     = '0;
                        end else begin
                            pulse_next = 1'b1;
                            miss_next  = '0;
                        end
                    end else if (meas_x == hi_x) begin
                        // Edge overdue: synthesize one, or give up after MISS_LIMIT.
                        if (miss_cnt == MSW'(MISS_LIMIT)) begin
                            state_next = IDLE;
                        end else begin
                            pulse_next = 1'b1;
                            synth_next = 1'b1;
                            phase_next = TOL_W;
                            miss_next  = miss_cnt + MSW'(1);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            phase_cnt  <= '0;
            ref_period <= '0;
            ref_valid  <= 1'b0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            sync_pulse <= 1'b0;
            synth_flag <= 1'b0;
            locked     <= 1'b0;
            period     <= '0;
        end else begin
            state      <= state_next;
            sync_1     <= signal;
            sync_2     <= sync_1;
            phase_cnt  <= phase_next;
            ref_period <= ref_next;
            ref_valid  <= ref_valid_next;
            match_cnt  <= match_next;
            miss_cnt   <= miss_next;
            sync_pulse <= pulse_next;
            synth_flag <= synth_next;
            locked     <= (state == LOCKED);
            period     <= (state == LOCKED) ? ref_period : '0;
        end
    end

endmodule

// File: tb/tb_sync_flywheel.sv
// Directed bench for sync_flywheel: expected pulses are queued as edges are driven
// and matched (synthetic flag and spacing) as the DUT emits them.
module tb_sync_flywheel;

    logic        clk = 1'b0;
    logic        rst;
    logic        signal;
    logic        signal_exitence;
    logic        sync_pulse;
    logic        synth_flag;
    logic        locked;
    logic [31:0] period;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic synth;
        int   gap;      // 0 = spacing not checked
    } exp_t;

    exp_t exp_q[$];
    int   cycle      = 0;
    int   last_pulse = 0;

    sync_flywheel #(
        .WIDTH(32),
        .PERIOD_TOL(2),
        .LOCK_COUNT(4),
        .MISS_LIMIT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .signal(signal),
        .signal_exitence(signal_exitence),
        .sync_pulse(sync_pulse),
        .synth_flag(synth_flag),
        .locked(locked),
        .period(period)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cycle);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One rising edge on signal, spaced gap clocks after the previous call's edge.
    task automatic send_edge(input int gap);
        signal = 1'b0;
        tick(gap - 1);
        signal = 1'b1;
        tick(1);
        signal = 1'b0;
    endtask

    task automatic expect_pulse(input logic synth, input int gap);
        exp_t e;
        e.synth = synth;
        e.gap   = gap;
        exp_q.push_back(e);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    // Five edges at spacing 20 from IDLE; lock must wait for the fifth.
    task automatic lock20();
        for (int i = 0; i < 4; i++) send_edge(20);
        tick(3);
        check("lock_after_4_edges", locked, 1'b0);
        send_edge(17);
        tick(3);
        check("lock_after_5_edges", locked, 1'b1);
        check("lock_period", period, 32'd20);
    endtask

    always @(negedge clk) begin
        exp_t e;
        cycle++;
        if (sync_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", sync_pulse, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_synth_flag", synth_flag, e.synth);
                if (e.gap != 0) check("pulse_spacing", cycle - last_pulse, e.gap);
            end
            last_pulse = cycle;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        signal          = 1'b0;
        signal_exitence = 1'b0;
        tick(3);
        check("rst_sync_pulse", sync_pulse, 1'b0);
        check("rst_synth_flag", synth_flag, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_period", period, 32'd0);
        rst = 1'b0;
        signal_exitence = 1'b1;
        tick(2);

        // Clean 20-clock edges: lock on the fifth, then one real pulse per edge.
        lock20();
        expect_pulse(1'b0, 0);
        send_edge(17);
        for (int i = 0; i < 3; i++) begin
            expect_pulse(1'b0, 20);
            send_edge(20);
        end

        // Jitter of +-1 stays locked; a 23-clock gap forces a synthetic pulse at 22.
        for (int i = 0; i < 4; i++) begin
            expect_pulse(1'b0, (i % 2 == 0) ? 19 : 21);
            send_edge((i % 2 == 0) ? 19 : 21);
        end
        tick(3);
        check("jitter_locked", locked, 1'b1);
        check("jitter_period", period, 32'd20);
        check("jitter_drained", exp_q.size(), 0);
        expect_pulse(1'b1, 22);
        send_edge(20);
        tick(5);
        check("late_edge_unlocked", locked, 1'b0);
        check("late_edge_period", period, 32'd0);
        check("late_edge_drained", exp_q.size(), 0);

        // Edges stop: three synthetic pulses 20 apart, then drop to IDLE.
        pulse_rst();
        lock20();
        expect_pulse(1'b0, 0);
        send_edge(17);
        expect_pulse(1'b1, 22);
        expect_pulse(1'b1, 20);
        expect_pulse(1'b1, 20);
        tick(70);
        check("coast_still_locked", locked, 1'b1);
        tick(40);
        check("coast_unlocked", locked, 1'b0);
        check("coast_period", period, 32'd0);
        check("coast_drained", exp_q.size(), 0);

        // Early edge at 10: unlock without a pulse, then re-lock with ref 10.
        pulse_rst();
        lock20();
        expect_pulse(1'b0, 0);
        send_edge(17);
        send_edge(10);
        tick(4);
        check("early_unlocked", locked, 1'b0);
        check("early_period", period, 32'd0);
        send_edge(6);
        send_edge(10);
        tick(3);
        check("early_reacq_pending", locked, 1'b0);
        send_edge(7);
        tick(3);
        check("early_relocked", locked, 1'b1);
        check("early_ref_10", period, 32'd10);
        check("early_drained", exp_q.size(), 0);

        // Presence flag drops: lock lost, edges no longer produce pulses.
        expect_pulse(1'b0, 0);
        send_edge(7);
        tick(3);
        signal_exitence = 1'b0;
        tick(2);
        check("absent_unlocked", locked, 1'b0);
        for (int i = 0; i < 6; i++) send_edge(10);
        tick(3);
        check("absent_still_unlocked", locked, 1'b0);
        check("absent_period", period, 32'd0);
        check("absent_drained", exp_q.size(), 0);

        // One-clock reset mid-lock clears everything; re-lock needs five fresh edges.
        signal_exitence = 1'b1;
        tick(2);
        lock20();
        expect_pulse(1'b0, 0);
        send_edge(17);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_locked", locked, 1'b0);
        check("midrst_period", period, 32'd0);
        check("midrst_sync_pulse", sync_pulse, 1'b0);
        check("midrst_synth_flag", synth_flag, 1'b0);
        lock20();
        tick(5);
        check("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
